// File: rtl/adc_ltc2308_responder_if.sv
// rtl/adc_ltc2308_responder_if.sv - pin and channel-data bundle between adc_control side and the LTC2308 responder
interface adc_ltc2308_responder_if;
    logic        ADC_SCLK;
    logic        ADC_CONVST;
    logic        ADC_SDI;
    logic        ADC_SDO;
    logic [95:0] CH_DATA;
    logic [5:0]  CFG_WORD;
    logic        CFG_VALID;
    logic        FRAME_ERR;

    modport master (
        output ADC_SCLK, ADC_CONVST, ADC_SDI, CH_DATA,
        input  ADC_SDO, CFG_WORD, CFG_VALID, FRAME_ERR
    );

    modport slave (
        input  ADC_SCLK, ADC_CONVST, ADC_SDI, CH_DATA,
        output ADC_SDO, CFG_WORD, CFG_VALID, FRAME_ERR
    );
endinterface

// File: rtl/adc_ltc2308_responder.sv
// rtl/adc_ltc2308_responder.sv - device-side model of an 8-channel 12-bit SPI ADC with pipelined results
module adc_ltc2308_responder #(
    parameter int CONV_CYCLES = 80
) (
    input  logic                          CLOCK,
    input  logic                          RESET,
    adc_ltc2308_responder_if.slave        bus
);
    localparam int CW = $clog2(CONV_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CONV, READY, SHIFT} state_t;
    state_t state, state_nxt;

    logic [2:0]    sclk_q, cnv_q, sdi_q;
    logic          sclk_rise, sclk_fall, cnv_rise, cnv_fall;
    logic [CW-1:0] busy_cnt;
    logic [11:0]   sample;
    logic [10:0]   shreg;
    logic [2:0]    rx_cnt;
    logic [3:0]    tx_cnt;
    logic [4:0]    cfg_sr;
    logic [5:0]    cfg_word;
    logic          sdo, cfg_valid, frame_err;

    logic          start_conv, start_frame, do_rx, do_tx, err;
    logic [2:0]    chan;
    logic [6:0]    ch_base;
    logic [5:0]    cfg_shifted;

    assign chan        = {cfg_word[3], cfg_word[2], cfg_word[4]};
    assign ch_base     = 7'(chan) * 7'd12;
    assign cfg_shifted = {cfg_sr, sdi_q[2]};

    assign bus.ADC_SDO   = sdo;
    assign bus.CFG_WORD  = cfg_word;
    assign bus.CFG_VALID = cfg_valid;
    assign bus.FRAME_ERR = frame_err;

    // Two sync flops, a third for the previous value, and registered edge pulses.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sclk_q    <= '0;
            cnv_q     <= '0;
            sdi_q     <= '0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cnv_rise  <= 1'b0;
            cnv_fall  <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[1:0], bus.ADC_SCLK};
            cnv_q     <= {cnv_q[1:0], bus.ADC_CONVST};
            sdi_q     <= {sdi_q[1:0], bus.ADC_SDI};
            sclk_rise <= sclk_q[1] & ~sclk_q[2];
            sclk_fall <= ~sclk_q[1] & sclk_q[2];
            cnv_rise  <= cnv_q[1] & ~cnv_q[2];
            cnv_fall  <= ~cnv_q[1] & cnv_q[2];
        end
    end

    always_comb begin
        state_nxt   = state;
        start_conv  = 1'b0;
        start_frame = 1'b0;
        do_rx       = 1'b0;
        do_tx       = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                if (cnv_rise) begin
                    start_conv = 1'b1;
                    state_nxt  = CONV;
                end
                err = sclk_rise | sclk_fall;
            end
            CONV: begin
                err = cnv_rise | cnv_fall | sclk_rise | sclk_fall;
                if (busy_cnt == '0)
                    state_nxt = READY;
            end
            READY: begin
                // A rise here only follows an aborted frame; it restarts the pipeline.
                if (cnv_fall) begin
                    start_frame = 1'b1;
                    state_nxt   = SHIFT;
                end else if (cnv_rise) begin
                    start_conv = 1'b1;
                    state_nxt  = CONV;
                end
                err = sclk_rise | sclk_fall;
            end
            SHIFT: begin
                if (cnv_rise) begin
                    start_conv = 1'b1;
                    state_nxt  = CONV;
                    err        = (rx_cnt < 3'd6);
                end else begin
                    do_rx = sclk_rise && (rx_cnt < 3'd6);
                    do_tx = sclk_fall && (tx_cnt < 4'd12);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= IDLE;
            busy_cnt  <= '0;
            sample    <= '0;
            shreg     <= '0;
            rx_cnt    <= '0;
            tx_cnt    <= '0;
            cfg_sr    <= '0;
            cfg_word  <= 6'b100010;
            sdo       <= 1'b0;
            cfg_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cfg_valid <= 1'b0;
            frame_err <= err;
            if (state == CONV && busy_cnt != '0)
                busy_cnt <= busy_cnt - CW'(1);
            if (start_conv) begin
                sample   <= bus.CH_DATA[ch_base +: 12];
                busy_cnt <= CW'(CONV_CYCLES - 1);
                sdo      <= 1'b0;
            end
            if (start_frame) begin
                shreg  <= sample[10:0];
                sdo    <= sample[11];
                rx_cnt <= '0;
                tx_cnt <= '0;
            end
            if (do_rx) begin
                cfg_sr <= cfg_shifted[4:0];
                rx_cnt <= rx_cnt + 3'd1;
                if (rx_cnt == 3'd5) begin
                    cfg_word  <= cfg_shifted;
                    cfg_valid <= 1'b1;
                end
            end
            // Zeros shift in behind the data, so the 12th fall drives SDO low.
            if (do_tx) begin
                sdo    <= shreg[10];
                shreg  <= {shreg[9:0], 1'b0};
                tx_cnt <= tx_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_adc_ltc2308_responder.sv
// tb/tb_adc_ltc2308_responder.sv - directed and randomized frames against a pipelined ADC reference model
module tb_adc_ltc2308_responder;
    localparam int CONV = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_ltc2308_responder_if bus();

    adc_ltc2308_responder #(.CONV_CYCLES(CONV)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int n_err = 0;

    logic [11:0] ch [8];
    logic [5:0]  model_cfg;
    logic [11:0] pend;
    logic [11:0] exp_w, got;
    logic [5:0]  rb;
    logic        sdo_or;
    int          e0, v0, idx;

    always @(negedge clk) begin
        if (bus.CFG_VALID) n_valid++;
        if (bus.FRAME_ERR) n_err++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int chan_of(input logic [5:0] c);
        return int'(c[3]) * 4 + int'(c[2]) * 2 + int'(c[4]);
    endfunction

    task automatic apply_ch();
        for (int i = 0; i < 8; i++)
            bus.CH_DATA[12*i +: 12] = ch[i];
    endtask

    task automatic randomize_ch();
        for (int i = 0; i < 8; i++)
            ch[i] = 12'($urandom);
        apply_ch();
    endtask

    // Conversion start: the device samples the channel named by the config in force.
    task automatic start_conv();
        bus.ADC_CONVST = 1'b1;
        pend = ch[chan_of(model_cfg)];
        wait_cyc(CONV + 20);
    endtask

    task automatic run_frame(input logic [5:0] bits, input int nclk, output logic [11:0] word);
        bus.ADC_CONVST = 1'b0;
        wait_cyc(8);
        word = '0;
        for (int i = 0; i < nclk; i++) begin
            bus.ADC_SDI = (i < 6) ? bits[5-i] : 1'b0;
            wait_cyc(6);
            if (i < 12) word[11-i] = bus.ADC_SDO;
            bus.ADC_SCLK = 1'b1;
            wait_cyc(6);
            bus.ADC_SCLK = 1'b0;
        end
        wait_cyc(6);
        if (nclk >= 6) model_cfg = bits;
    endtask

    initial begin
        bus.ADC_SCLK   = 1'b0;
        bus.ADC_CONVST = 1'b0;
        bus.ADC_SDI    = 1'b0;
        bus.CH_DATA    = '0;
        model_cfg      = 6'b100010;
        pend           = '0;
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(2);

        check("reset_sdo", 32'(bus.ADC_SDO), 32'd0);
        check("reset_cfg", 32'(bus.CFG_WORD), 32'h22);
        check("reset_valid", 32'(bus.CFG_VALID), 32'd0);
        check("reset_err", 32'(bus.FRAME_ERR), 32'd0);

        // First frame after reset returns CH0.
        randomize_ch();
        ch[0] = 12'hA5C;
        apply_ch();
        e0 = n_err;
        start_conv();
        v0 = n_valid;
        exp_w = pend;
        run_frame(6'b100010, 12, got);
        check("t1_data", 32'(got), 32'(exp_w));
        check("t1_data_const", 32'(got), 32'hA5C);
        check("t1_valid_count", n_valid - v0, 32'd1);
        check("t1_cfg", 32'(bus.CFG_WORD), 32'h22);
        check("t1_sdo_tail", 32'(bus.ADC_SDO), 32'd0);
        start_conv();
        check("t1_no_err", n_err - e0, 32'd0);

        // Channel change takes effect one frame later.
        ch[5] = 12'h123;
        apply_ch();
        exp_w = pend;
        run_frame(6'b111010, 12, got);
        check("t2_old_chan", 32'(got), 32'(exp_w));
        start_conv();
        exp_w = pend;
        run_frame(6'b111010, 12, got);
        check("t2_new_chan", 32'(got), 32'h123);

        for (int k = 0; k < 4; k++) begin
            randomize_ch();
            start_conv();
            rb = 6'($urandom);
            exp_w = pend;
            run_frame(rb, 12, got);
            check("rand_data", 32'(got), 32'(exp_w));
            check("rand_cfg", 32'(bus.CFG_WORD), 32'(model_cfg));
        end

        // CONVST falls mid-conversion.
        randomize_ch();
        bus.ADC_CONVST = 1'b1;
        pend = ch[chan_of(model_cfg)];
        wait_cyc(20);
        e0 = n_err;
        bus.ADC_CONVST = 1'b0;
        sdo_or = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.ADC_SDI = 1'b1;
            wait_cyc(6);
            sdo_or = sdo_or | bus.ADC_SDO;
            bus.ADC_SCLK = 1'b1;
            wait_cyc(6);
            bus.ADC_SCLK = 1'b0;
        end
        wait_cyc(6);
        check("viol_fall_err", 32'(n_err != e0), 32'd1);
        check("viol_fall_sdo", 32'(sdo_or), 32'd0);
        check("viol_fall_cfg", 32'(bus.CFG_WORD), 32'(model_cfg));
        randomize_ch();
        start_conv();
        exp_w = pend;
        run_frame(model_cfg, 12, got);
        check("viol_fall_recover", 32'(got), 32'(exp_w));

        // Early CONVST rise after 3 config bits.
        start_conv();
        exp_w = pend;
        rb = ~model_cfg;
        run_frame(rb, 3, got);
        check("partial_msbs", 32'(got[11:9]), 32'(exp_w[11:9]));
        e0 = n_err;
        randomize_ch();
        start_conv();
        check("partial_err", n_err - e0, 32'd1);
        check("partial_cfg", 32'(bus.CFG_WORD), 32'(model_cfg));
        exp_w = pend;
        run_frame(model_cfg, 12, got);
        check("partial_newconv", 32'(got), 32'(exp_w));

        // CH_DATA changes right after the rise is detected.
        idx = chan_of(model_cfg);
        bus.ADC_CONVST = 1'b1;
        pend = ch[idx];
        wait_cyc(5);
        ch[idx] = ~ch[idx];
        apply_ch();
        wait_cyc(CONV + 20);
        exp_w = pend;
        run_frame(model_cfg, 12, got);
        check("capture_hold", 32'(got), 32'(exp_w));

        // Reset after the 7th SCLK.
        start_conv();
        run_frame(6'b111010, 7, got);
        rst = 1'b1;
        wait_cyc(1);
        check("midreset_sdo", 32'(bus.ADC_SDO), 32'd0);
        check("midreset_cfg", 32'(bus.CFG_WORD), 32'h22);
        wait_cyc(3);
        rst = 1'b0;
        model_cfg = 6'b100010;
        pend = '0;
        wait_cyc(2);
        randomize_ch();
        start_conv();
        v0 = n_valid;
        exp_w = pend;
        run_frame(6'b100010, 12, got);
        check("postreset_data", 32'(got), 32'(ch[0]));
        check("postreset_valid", n_valid - v0, 32'd1);
        check("postreset_cfg", 32'(bus.CFG_WORD), 32'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
